// File: rtl/imem_load_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// imem_load_ctrl_pkg
// Shared parameters and state encoding for the instruction-memory load
// controller. Holds the default memory depth, the default flush length,
// the FSM state type and a small length-clamping helper.
// ----------------------------------------------------------------------------
package imem_load_ctrl_pkg;

  // Default instruction memory depth in 32-bit words
  localparam int IMEM_SIZE_DEFAULT    = 64;

  // Default number of cycles the fetch stage stays in reset after a load
  localparam int FLUSH_CYCLES_DEFAULT = 2;

  // Width of the flush cycle counter; comfortably wider than any sane flush
  localparam int FLUSH_CNT_W          = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_LOAD  = 3'd2,
    S_FLUSH = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  // A load can never be longer than the memory it fills
  function automatic int clamp_len(input int req, input int cap);
    return (req > cap) ? cap : req;
  endfunction

endpackage

// File: rtl/imem_load_ctrl.sv
// ----------------------------------------------------------------------------
// imem_load_ctrl
// Streams a program from an external loader into instruction memory by
// steering the fetch stage: the fetch PC is overridden so that it always
// points at the next word to write, the memory write enable follows the
// loader's valid, and after the last word the fetch stage is held in reset
// for FLUSH_CYCLES cycles before being released to run from PC 0.
//
// Ports
//   CLK         clock, all state changes on the rising edge
//   RST         synchronous, active-low reset
//   ld_start    one-cycle load request (honoured only in IDLE or RUN)
//   ld_len      requested word count, sampled with an accepted ld_start
//   ld_valid    loader word valid
//   ld_data     loader instruction word
//   ld_ready    controller accepts a word this cycle
//   cpu_rst     active-high reset to the fetch stage
//   pc_sel      selects pc_ovr as the fetch-stage next PC
//   pc_ovr      byte-address PC override
//   imem_we     instruction memory write enable (writes at current fetch PC)
//   imem_wdata  instruction memory write data (always ld_data)
//   busy        high in PRIME, LOAD and FLUSH
//   done        one-cycle pulse in the first RUN cycle after a load
//   words       words written in the last/current load
//
// FLUSH_CYCLES must be at least 1.
// ----------------------------------------------------------------------------
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int IMEM_SIZE    = IMEM_SIZE_DEFAULT,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       ld_start,
  input  logic [$clog2(IMEM_SIZE):0] ld_len,
  input  logic                       ld_valid,
  input  logic [31:0]                ld_data,
  output logic                       ld_ready,
  output logic                       cpu_rst,
  output logic                       pc_sel,
  output logic [31:0]                pc_ovr,
  output logic                       imem_we,
  output logic [31:0]                imem_wdata,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(IMEM_SIZE):0] words
);

  localparam int CW = $clog2(IMEM_SIZE) + 1;

  state_t                 state;
  logic [CW-1:0]          len;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic                   done_q;
  logic                   fire;
  logic                   last_word;

  assign last_word = ((words + CW'(1)) == len);

  // Output decode. Every output is forced to its reset value while RST is
  // low so that a word presented in the same cycle as a mid-load reset is
  // never written, even though the state register only clears on the edge.
  // In LOAD the override already points at the next slot when a word is
  // accepted, so the fetch PC lands on 4*words for every write.
  always_comb begin
    cpu_rst    = 1'b1;
    pc_sel     = 1'b0;
    pc_ovr     = '0;
    ld_ready   = 1'b0;
    imem_we    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    fire       = 1'b0;
    imem_wdata = ld_data;
    if (RST) begin
      case (state)
        S_PRIME: begin
          cpu_rst = 1'b0;
          pc_sel  = 1'b1;
          busy    = 1'b1;
        end
        S_LOAD: begin
          cpu_rst  = 1'b0;
          pc_sel   = 1'b1;
          ld_ready = 1'b1;
          imem_we  = ld_valid;
          fire     = ld_valid;
          busy     = 1'b1;
          pc_ovr   = (32'(words) + 32'(fire)) << 2;
        end
        S_FLUSH: begin
          busy = 1'b1;
        end
        S_RUN: begin
          cpu_rst = 1'b0;
          done    = done_q;
        end
        default: begin
        end
      endcase
    end
  end

  // Load sequencing. The flush counter is cleared in PRIME because every
  // path into FLUSH passes through PRIME first. done_q is set only on the
  // FLUSH->RUN edge and self-clears one cycle later.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= S_IDLE;
      words     <= '0;
      len       <= '0;
      flush_cnt <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE, S_RUN: begin
          if (ld_start) begin
            state <= S_PRIME;
            len   <= CW'(clamp_len(int'(ld_len), IMEM_SIZE));
            words <= '0;
          end
        end
        S_PRIME: begin
          flush_cnt <= '0;
          state     <= (len != '0) ? S_LOAD : S_FLUSH;
        end
        S_LOAD: begin
          if (fire) begin
            words <= words + CW'(1);
            if (last_word) begin
              state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (flush_cnt == FLUSH_CNT_W'(FLUSH_CYCLES - 1)) begin
            state  <= S_RUN;
            done_q <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + FLUSH_CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// ----------------------------------------------------------------------------
// tb_imem_load_ctrl
// Drives imem_load_ctrl through a sequence of program loads and checks its
// outputs against expectations derived from the load rules: words are
// written in arrival order at byte addresses 0,4,8,..., the count is
// clamped to the memory depth, stalls write nothing, the fetch stage is
// flushed for FLUSH cycles and then fetches from PC 0.
// A small fetch stage and instruction memory live in the bench so the
// write address and the fetched word can be checked end to end.
// ----------------------------------------------------------------------------
module tb_imem_load_ctrl;

  localparam int IMEM_SIZE = 64;
  localparam int FLUSH     = 2;
  localparam int LW        = $clog2(IMEM_SIZE) + 1;
  localparam int AW        = $clog2(IMEM_SIZE);

  logic          CLK = 1'b0;
  logic          RST;
  logic          ld_start;
  logic [LW-1:0] ld_len;
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_ready;
  logic          cpu_rst;
  logic          pc_sel;
  logic [31:0]   pc_ovr;
  logic          imem_we;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic [LW-1:0] words;

  int tests = 0;
  int fails = 0;

  logic [31:0] fpc;
  logic [31:0] mem [0:IMEM_SIZE-1];
  int          wrCount = 0;
  logic [31:0] expData [0:IMEM_SIZE-1];
  bit          inRun = 1'b0;

  imem_load_ctrl #(
    .IMEM_SIZE   (IMEM_SIZE),
    .FLUSH_CYCLES(FLUSH)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ld_start  (ld_start),
    .ld_len    (ld_len),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .cpu_rst   (cpu_rst),
    .pc_sel    (pc_sel),
    .pc_ovr    (pc_ovr),
    .imem_we   (imem_we),
    .imem_wdata(imem_wdata),
    .busy      (busy),
    .done      (done),
    .words     (words)
  );

  always #5 CLK = ~CLK;

  // Bench-side fetch stage and instruction memory: writes land at the
  // current fetch PC, the PC follows the override, reset, or increments.
  always @(posedge CLK) begin
    if (imem_we) begin
      mem[fpc[AW+1:2]] <= imem_wdata;
      wrCount          <= wrCount + 1;
    end
    if (cpu_rst)
      fpc <= 32'd0;
    else if (pc_sel)
      fpc <= pc_ovr;
    else
      fpc <= fpc + 32'd4;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then settle before sampling
  task automatic applyStimulus(input logic start, input logic [LW-1:0] len,
                               input logic valid, input logic [31:0] data);
    @(negedge CLK);
    ld_start = start;
    ld_len   = len;
    ld_valid = valid;
    ld_data  = data;
    #1;
  endtask

  // One complete load. Valid follows pat for the first patLen cycles, then
  // is random (randValid) or held high. pokeStart raises ld_start during
  // LOAD, which must be ignored. abortAt >= 0 pulls RST low once that many
  // words have been written.
  task automatic runLoad(input int reqLen, input int patLen, input logic [31:0] pat,
                         input bit randValid, input bit pokeStart, input int abortAt);
    int          expN;
    int          written;
    int          cyc;
    int          startWr;
    logic        v;
    logic [31:0] d;
    logic [31:0] saved;
    expN    = (reqLen > IMEM_SIZE) ? IMEM_SIZE : reqLen;
    startWr = wrCount;

    applyStimulus(1'b1, LW'(reqLen), 1'b0, $urandom);
    checkOutput("start_busy", {31'd0, busy}, 32'd0);
    checkOutput("start_cpurst", {31'd0, cpu_rst}, inRun ? 32'd0 : 32'd1);

    applyStimulus(1'b0, LW'($urandom), 1'b1, $urandom);
    checkOutput("prime_busy", {31'd0, busy}, 32'd1);
    checkOutput("prime_cpurst", {31'd0, cpu_rst}, 32'd0);
    checkOutput("prime_pcsel", {31'd0, pc_sel}, 32'd1);
    checkOutput("prime_pcovr", pc_ovr, 32'd0);
    checkOutput("prime_ready", {31'd0, ld_ready}, 32'd0);
    checkOutput("prime_we", {31'd0, imem_we}, 32'd0);
    checkOutput("prime_words", 32'(words), 32'd0);
    inRun = 1'b0;

    written = 0;
    cyc     = 0;
    while (written < expN && cyc < 4000) begin
      if (cyc < patLen)
        v = pat[cyc];
      else if (randValid)
        v = 1'($urandom);
      else
        v = 1'b1;
      d = $urandom;
      if (written == abortAt) begin
        saved = mem[abortAt];
        @(negedge CLK);
        RST      = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_data  = d;
        #1;
        checkOutput("abort_we", {31'd0, imem_we}, 32'd0);
        checkOutput("abort_ready", {31'd0, ld_ready}, 32'd0);
        checkOutput("abort_cpurst", {31'd0, cpu_rst}, 32'd1);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge CLK);
        RST      = 1'b1;
        ld_valid = 1'b0;
        #1;
        checkOutput("idle_cpurst", {31'd0, cpu_rst}, 32'd1);
        checkOutput("idle_pcsel", {31'd0, pc_sel}, 32'd0);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("idle_words", 32'(words), 32'd0);
        checkOutput("abort_wrcount", 32'(wrCount - startWr), 32'(abortAt));
        checkOutput("abort_nowrite", mem[abortAt], saved);
        return;
      end
      applyStimulus(pokeStart && (cyc == 1), LW'($urandom), v, d);
      checkOutput("load_ready", {31'd0, ld_ready}, 32'd1);
      checkOutput("load_busy", {31'd0, busy}, 32'd1);
      checkOutput("load_we", {31'd0, imem_we}, {31'd0, v});
      checkOutput("load_wdata", imem_wdata, d);
      checkOutput("load_pcovr", pc_ovr, 32'(4 * (written + int'(v))));
      checkOutput("load_words", 32'(words), 32'(written));
      if (v) begin
        checkOutput("load_waddr", fpc, 32'(4 * written));
        expData[written] = d;
        written++;
      end
      cyc++;
    end
    checkOutput("load_count", 32'(written), 32'(expN));

    for (int i = 0; i < FLUSH; i++) begin
      d = $urandom;
      applyStimulus(1'b0, LW'($urandom), 1'b1, d);
      checkOutput("flush_cpurst", {31'd0, cpu_rst}, 32'd1);
      checkOutput("flush_pcsel", {31'd0, pc_sel}, 32'd0);
      checkOutput("flush_ready", {31'd0, ld_ready}, 32'd0);
      checkOutput("flush_we", {31'd0, imem_we}, 32'd0);
      checkOutput("flush_busy", {31'd0, busy}, 32'd1);
      checkOutput("flush_done", {31'd0, done}, 32'd0);
      checkOutput("flush_wdata", imem_wdata, d);
    end

    applyStimulus(1'b0, LW'($urandom), 1'b0, $urandom);
    checkOutput("run_done", {31'd0, done}, 32'd1);
    checkOutput("run_busy", {31'd0, busy}, 32'd0);
    checkOutput("run_cpurst", {31'd0, cpu_rst}, 32'd0);
    checkOutput("run_pcsel", {31'd0, pc_sel}, 32'd0);
    checkOutput("run_words", 32'(words), 32'(expN));
    checkOutput("run_fetchpc", fpc, 32'd0);
    checkOutput("run_wrcount", 32'(wrCount - startWr), 32'(expN));
    if (expN > 0)
      checkOutput("run_fetch0", mem[0], expData[0]);
    for (int k = 0; k < expN; k++)
      checkOutput("mem_word", mem[k], expData[k]);

    applyStimulus(1'b0, LW'($urandom), 1'b0, $urandom);
    checkOutput("run2_done", {31'd0, done}, 32'd0);
    checkOutput("run2_fetchpc", fpc, 32'd4);
    inRun = 1'b1;
  endtask

  initial begin
    RST      = 1'b0;
    ld_start = 1'b0;
    ld_len   = '0;
    ld_valid = 1'b1;
    ld_data  = $urandom;

    // Reset held across two edges with a valid word presented
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    checkOutput("rst_cpurst", {31'd0, cpu_rst}, 32'd1);
    checkOutput("rst_pcsel", {31'd0, pc_sel}, 32'd0);
    checkOutput("rst_pcovr", pc_ovr, 32'd0);
    checkOutput("rst_ready", {31'd0, ld_ready}, 32'd0);
    checkOutput("rst_we", {31'd0, imem_we}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_words", 32'(words), 32'd0);
    RST = 1'b1;

    // IDLE ignores a valid loader word
    applyStimulus(1'b0, '0, 1'b1, $urandom);
    checkOutput("idle_ready", {31'd0, ld_ready}, 32'd0);
    checkOutput("idle_we", {31'd0, imem_we}, 32'd0);
    checkOutput("idle_cpurst", {31'd0, cpu_rst}, 32'd1);

    // Three words with valid held high
    runLoad(3, 0, 32'd0, 1'b0, 1'b0, -1);
    // Four words with valid toggling 1,0,0,1,1,0,1 (LSB first)
    runLoad(4, 7, 32'b1011001, 1'b0, 1'b0, -1);
    // Empty load goes straight through to flush
    runLoad(0, 0, 32'd0, 1'b0, 1'b0, -1);
    // Oversized request is clamped to the memory depth
    runLoad(100, 0, 32'd0, 1'b1, 1'b0, -1);
    // Reset after two of five words, with a stray start during LOAD
    runLoad(5, 0, 32'd0, 1'b0, 1'b1, 2);
    // Load, then reload a single word from RUN
    runLoad(2, 0, 32'd0, 1'b1, 1'b0, -1);
    runLoad(1, 0, 32'd0, 1'b0, 1'b0, -1);
    // Random loads
    for (int n = 0; n < 4; n++)
      runLoad($urandom_range(0, 80), 0, 32'd0, 1'b1, 1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
